video_acc_sequencer: RTL



---
 rtl/video_acc_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/video_acc_sequencer.sv
// Instruction sequencer: pops opcodes, sets router dest, starts src/dst movers, retires when both idle.
// Latency pop->retire 4 edges minimum; each start valid holds until its ready, fetch stalls while busy or halted.
module video_acc_sequencer #(
    parameter int DEST_WIDTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  inst_valid,
    input  logic [31:0]           inst_data,
    output logic                  inst_pop,
    input  logic                  halt,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  dst_valid,
    input  logic                  dst_ready,
    output logic [DEST_WIDTH-1:0] routing_dest,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  retired,
    output logic                  illegal,
    input  logic                  illegal_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] opcode;
    logic       op_nop;
    logic       op_legal;
    logic       start_inst;
    logic       retire;
    logic       unused_hi;

    assign opcode    = inst_data[5:0];
    assign unused_hi = ^inst_data[31:6];
    assign op_nop    = (opcode == 6'h00);
    // MOV/DCT/IDCT/CHROMA occupy 0x08..0x0B; the low two bits are the destination
    assign op_legal  = (opcode[5:2] == 4'b0010);

    assign inst_pop   = aresetn && (state == IDLE) && inst_valid && !halt;
    assign start_inst = inst_pop && op_legal;
    assign retire     = (state == WAIT) && src_ready && dst_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_inst) state_nxt = START;
            // one full cycle with both valids low keeps WAIT off a stale ready
            START:   if (!src_valid && !dst_valid) state_nxt = WAIT;
            WAIT:    if (retire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            src_valid    <= 1'b0;
            dst_valid    <= 1'b0;
            routing_dest <= '0;
            retired      <= '0;
            illegal      <= 1'b0;
        end else begin
            if (start_inst) begin
                src_valid    <= 1'b1;
                dst_valid    <= 1'b1;
                routing_dest <= DEST_WIDTH'(opcode[1:0]);
            end else begin
                if (src_valid && src_ready) src_valid <= 1'b0;
                if (dst_valid && dst_ready) dst_valid <= 1'b0;
            end

            if (retire) retired <= retired + 1'b1;

            if (inst_pop && !op_legal && !op_nop) begin
                illegal <= 1'b1;
            end else if (illegal_clr) begin
                illegal <= 1'b0;
            end
        end
    end

endmodule
